// File: rtl/sha1_arb_pkg.sv
// rtl/sha1_arb_pkg.sv - shared state encoding and word width for the sha1_dfa arbiter
package sha1_arb_pkg;

   localparam int WORD_W = 32;
   localparam int ST_W   = 3;

   typedef logic [WORD_W-1:0] word_t;

   localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
   localparam logic [ST_W-1:0] ST_ISSUE     = 3'd1;
   localparam logic [ST_W-1:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [ST_W-1:0] ST_RUN       = 3'd3;
   localparam logic [ST_W-1:0] ST_DRAIN     = 3'd4;
   localparam logic [ST_W-1:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/sha1_arb_rr_pick.sv
// rtl/sha1_arb_rr_pick.sv - combinational round-robin selector, scans from ptr+1 upward with wrap
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   int j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            idx_o    = IW'(j);
            gnt_o[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha1_arb.sv
// rtl/sha1_arb.sv - round-robin owner FSM sharing one sha1_dfa engine between NREQ requesters
// Optional watchdog with err_o strobe: define SHA1_ARB_TIMEOUT_EN.
module sha1_arb
   import sha1_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int TMO_W = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ*WORD_W-1:0] para_i,
   input  logic [NREQ*WORD_W-1:0] addr_i,
   output logic [NREQ-1:0]        gnt_o,
   output logic [NREQ-1:0]        done_o,
   output logic [NREQ-1:0]        err_o,
   output logic [WORD_W-1:0]      result_o,
   output logic [WORD_W-1:0]      eng_para_o,
   output logic                   eng_start_o,
   output logic [WORD_W-1:0]      eng_addr_o,
   input  logic [WORD_W-1:0]      eng_result_i,
   input  logic                   eng_ready_i,
   input  logic                   eng_busy_i,
   input  logic                   eng_wbusy_i,
   output logic                   busy_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [ST_W-1:0] state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   word_t           para_q, para_d;
   word_t           addr_q, addr_d;
   word_t           res_q, res_d;

   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            tmo;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      para_d  = para_q;
      addr_d  = addr_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_ISSUE;
               gnt_d   = pick_gnt;
               ptr_d   = pick_idx;
               para_d  = para_i[WORD_W*int'(pick_idx) +: WORD_W];
               addr_d  = addr_i[WORD_W*int'(pick_idx) +: WORD_W];
            end
         end
         ST_ISSUE:     state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            // a zero-cycle engine may already report ready without ever raising busy
            if (eng_busy_i)       state_d = ST_RUN;
            else if (eng_ready_i) state_d = ST_DRAIN;
         end
         ST_RUN: begin
            if (!eng_busy_i && eng_ready_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!eng_wbusy_i) begin
               res_d   = eng_result_i;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      if (tmo) begin
         state_d = ST_IDLE;
         gnt_d   = '0;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= IW'(NREQ - 1);
         gnt_q   <= '0;
         para_q  <= '0;
         addr_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         para_q  <= para_d;
         addr_q  <= addr_d;
         res_q   <= res_d;
      end
   end

`ifdef SHA1_ARB_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]  err_q;
   logic             timed;

   assign timed = (state_q == ST_WAIT_BUSY) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
   // fires as the counter would reach all-ones, i.e. after 2**TMO_W-1 cycles in one state
   assign tmo   = timed && (cnt_q == TMO_LAST);
   assign cnt_d = (state_d != state_q) ? '0 : (timed ? cnt_q + 1'b1 : cnt_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= tmo ? gnt_q : '0;
      end
   end

   assign err_o = err_q;
`else
   assign tmo   = 1'b0;
   assign err_o = '0;
`endif

   assign gnt_o       = gnt_q;
   assign done_o      = (state_q == ST_DONE) ? gnt_q : '0;
   assign eng_start_o = (state_q == ST_ISSUE);
   assign eng_para_o  = para_q;
   assign eng_addr_o  = addr_q;
   assign result_o    = res_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha1_arb.sv
// tb/tb_sha1_arb.sv - self-checking bench: directed table, corner sequences, randomized jobs vs rotation model
module tb_sha1_arb;

   localparam int NREQ = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [1:0]      req_i = '0;
   logic [63:0]     para_i, addr_i;
   logic [1:0]      gnt_o, done_o, err_o;
   logic [31:0]     result_o, eng_para_o, eng_addr_o;
   logic            eng_start_o, busy_o;
   logic [31:0]     eng_result_i = '0;
   logic            eng_ready_i = 1'b0, eng_busy_i = 1'b0, eng_wbusy_i = 1'b0;

   logic [31:0]     para [2];
   logic [31:0]     addr [2];
   assign para_i = {para[1], para[0]};
   assign addr_i = {addr[1], addr[0]};

   always #5 clk = ~clk;

   sha1_arb #(.NREQ(NREQ), .TMO_W(4)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .para_i(para_i), .addr_i(addr_i),
      .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
      .eng_para_o(eng_para_o), .eng_start_o(eng_start_o), .eng_addr_o(eng_addr_o),
      .eng_result_i(eng_result_i), .eng_ready_i(eng_ready_i), .eng_busy_i(eng_busy_i),
      .eng_wbusy_i(eng_wbusy_i), .busy_o(busy_o)
   );

   // Engine model: start seen in cycle t=1, busy for cycles 2..C+1, ready from C+2,
   // write-back busy for cycles C+3..C+2+WB; result word changes every cycle.
   int          cfg_c = 0, cfg_wb = 0;
   bit          stuck = 1'b0;
   bit          act = 1'b0;
   int          t = 0, ec = 0, ew = 0;
   logic [31:0] res_base = 32'hC0DE_0000;

   always @(negedge clk) begin
      if (!rst) act = 1'b0;
      else if (eng_start_o) begin act = 1'b1; t = 1; ec = cfg_c; ew = cfg_wb; end
      else if (act) t++;
      eng_busy_i   = act && (stuck || (t >= 2 && t <= ec + 1));
      eng_ready_i  = act && !stuck && (t >= ec + 2);
      eng_wbusy_i  = act && !stuck && (t >= ec + 3) && (t < ec + 3 + ew);
      eng_result_i = res_base + 32'(t);
   end

   int          n_chk = 0, n_pass = 0;
   logic [31:0] last_res = '0;

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_chk++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
   endtask

   task automatic wait_start(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!eng_start_o && n < 30);
      chk("start_seen", 32'(eng_start_o), 32'd1);
   endtask

   task automatic serve(input int own, input int c, input int wb, input bit drop, output int waited);
      int  n;
      bit  ok;
      logic [31:0] exp_res;
      cfg_c = c; cfg_wb = wb;
      wait_start(waited);
      if (!eng_start_o) return;
      chk("gnt_owner", 32'(gnt_o), 32'(1 << own));
      chk("eng_para", eng_para_o, para[own]);
      chk("eng_addr", eng_addr_o, addr[own]);
      chk("busy_in_job", 32'(busy_o), 32'd1);
      if (drop) req_i = '0;
      n = 0; ok = 1'b1;
      do begin
         @(negedge clk); n++;
         if (eng_start_o || gnt_o != 2'(1 << own)) ok = 1'b0;
      end while (done_o == '0 && n < 300);
      exp_res = res_base + 32'(c + 3 + wb);
      chk("single_start_gnt_held", 32'(ok), 32'd1);
      chk("latency", 32'(n), 32'(c + 3 + wb));
      chk("done_owner", 32'(done_o), 32'(1 << own));
      chk("result", result_o, exp_res);
      chk("err_quiet", 32'(err_o), 32'd0);
      last_res = exp_res;
      @(negedge clk);
      chk("idle_after_done", 32'({busy_o, done_o, gnt_o}), 32'd0);
   endtask

   function automatic int rr_model(input logic [1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   typedef struct {
      logic [1:0] req;
      int         c;
      int         wb;
      int         own;
      bit         drop;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int w, n, own, last;
      tbl[0] = '{2'b01, 3, 0, 0, 1'b0};
      tbl[1] = '{2'b11, 2, 0, 1, 1'b0};
      tbl[2] = '{2'b11, 0, 0, 0, 1'b0};
      tbl[3] = '{2'b11, 1, 0, 1, 1'b0};
      tbl[4] = '{2'b10, 4, 5, 1, 1'b0};
      tbl[5] = '{2'b01, 2, 3, 0, 1'b0};
      tbl[6] = '{2'b01, 5, 0, 0, 1'b1};
      tbl[7] = '{2'b11, 0, 2, 1, 1'b0};
      para[0] = 32'h3132_3334; addr[0] = 32'h1000_1000;
      para[1] = 32'hA5A5_0001; addr[1] = 32'h2000_2000;

      repeat (3) @(negedge clk);
      chk("reset_gnt_done_err", 32'({gnt_o, done_o, err_o}), 32'd0);
      chk("reset_busy_start", 32'({busy_o, eng_start_o}), 32'd0);
      chk("reset_result", result_o, 32'd0);
      chk("reset_para_addr", eng_para_o | eng_addr_o, 32'd0);

      // contention at reset release, then strict alternation with both held
      req_i = 2'b11;
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 4; i++) serve(i % 2, 1 + i, 0, 1'b0, w);

      for (int i = 0; i < 8; i++) begin
         req_i = tbl[i].req;
         serve(tbl[i].own, tbl[i].c, tbl[i].wb, tbl[i].drop, w);
      end

      // late request while requester 0 runs
      req_i = 2'b01;
      fork
         serve(0, 6, 0, 1'b0, w);
         begin repeat (5) @(negedge clk); req_i[1] = 1'b1; end
      join
      req_i = 2'b10;
      serve(1, 2, 0, 1'b0, w);
      chk("late_issue_gap", 32'(w), 32'd1);
      req_i = '0;
      repeat (2) @(negedge clk);

      // reset mid-job; pointer must return to NREQ-1 so requester 0 wins
      req_i = 2'b01; cfg_c = 10;
      wait_start(n);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_gnt_done_err", 32'({gnt_o, done_o, err_o}), 32'd0);
      chk("midrst_busy_start", 32'({busy_o, eng_start_o}), 32'd0);
      chk("midrst_result", result_o, 32'd0);
      chk("midrst_para_addr", eng_para_o | eng_addr_o, 32'd0);
      @(negedge clk);
      rst = 1'b1; req_i = 2'b11;
      serve(0, 2, 1, 1'b0, w);

      // randomized jobs against the rotation model
      last = 0;
      for (int i = 0; i < 24; i++) begin
         logic [1:0] r;
         r = 2'($urandom_range(1, 3));
         para[0] = $urandom; para[1] = $urandom;
         addr[0] = $urandom; addr[1] = $urandom;
         own = rr_model(r, last);
         req_i = r;
         serve(own, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
         last = own;
      end
      req_i = '0;
      repeat (2) @(negedge clk);

`ifdef SHA1_ARB_TIMEOUT_EN
      stuck = 1'b1; req_i = 2'b01;
      wait_start(n);
      n = 0;
      do begin @(negedge clk); n++; end while (err_o == '0 && done_o == '0 && n < 100);
      chk("tmo_cycles", 32'(n), 32'd17);
      chk("tmo_err", 32'(err_o), 32'b01);
      chk("tmo_no_done", 32'(done_o), 32'd0);
      chk("tmo_result_kept", result_o, last_res);
      chk("tmo_idle", 32'({busy_o, gnt_o}), 32'd0);
      stuck = 1'b0; req_i = '0;
      repeat (2) @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
